y_position_mover: RTL and testbench

//   Parametrised vertical-position register for the falling/stacking block.

---
 rtl/y_position_mover.sv | 123 ++++++++++++
 tb/tb_y_position_mover.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/y_position_mover.sv
// Vertical-position register for the falling block: hold, parallel load,
// bounded single steps and a tick-paced glide toward a clamped target row.
module y_position_mover #(
  parameter int WIDTH    = 7,
  parameter int INIT     = 104,
  parameter int MIN_POS  = 0,
  parameter int MAX_POS  = 119,
  parameter int STEP     = 16,
  parameter int TICK_DIV = 833333
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             parload,
  input  logic [WIDTH-1:0] value,
  input  logic             move_start,
  input  logic [WIDTH-1:0] target,
  input  logic             step_up,
  input  logic             step_dn,
  output logic [WIDTH-1:0] pos,
  output logic             busy,
  output logic             done
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(TICK_DIV);

  typedef logic signed [AW-1:0] sval_t;

  localparam sval_t            MIN_S  = sval_t'(MIN_POS);
  localparam sval_t            MAX_S  = sval_t'(MAX_POS);
  localparam sval_t            STEP_S = sval_t'(STEP);
  localparam logic [CW-1:0]    LAST   = CW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  typedef enum logic {IDLE, GLIDE} state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt;
  logic [CW-1:0]    cnt;

  sval_t            p_s, t_s, diff, up_s, dn_s, gl_s;
  logic [WIDTH-1:0] up_pos, dn_pos, glide_pos, value_c, target_c;

  function automatic logic [WIDTH-1:0] clampv(input logic [WIDTH-1:0] x);
    sval_t s;
    s = signed'({2'b00, x});
    if (s < MIN_S) s = MIN_S;
    if (s > MAX_S) s = MAX_S;
    return s[WIDTH-1:0];
  endfunction

  // Two extra bits keep pos +/- STEP representable without wrap before clamping.
  always_comb begin
    p_s  = signed'({2'b00, pos});
    t_s  = signed'({2'b00, tgt});
    up_s = p_s + STEP_S;
    if (up_s > MAX_S) up_s = MAX_S;
    dn_s = p_s - STEP_S;
    if (dn_s < MIN_S) dn_s = MIN_S;
    diff = t_s - p_s;
    if (diff > STEP_S)       gl_s = p_s + STEP_S;
    else if (diff < -STEP_S) gl_s = p_s - STEP_S;
    else                     gl_s = t_s;
    up_pos    = up_s[WIDTH-1:0];
    dn_pos    = dn_s[WIDTH-1:0];
    glide_pos = gl_s[WIDTH-1:0];
    value_c   = clampv(value);
    target_c  = clampv(target);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      pos   <= INIT_V;
      tgt   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (parload) begin
        pos   <= value_c;
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (move_start) begin
              tgt <= target_c;
              if (target_c == pos) begin
                done <= 1'b1;
              end else begin
                state <= GLIDE;
                busy  <= 1'b1;
                cnt   <= '0;
              end
            end else if (step_up && !step_dn) begin
              pos <= up_pos;
            end else if (step_dn && !step_up) begin
              pos <= dn_pos;
            end
          end
          GLIDE: begin
            if (cnt == LAST) begin
              cnt <= '0;
              pos <= glide_pos;
              if (glide_pos == tgt) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_y_position_mover.sv
// Bench for y_position_mover: directed scenarios with literal expectations
// plus random traffic, all compared every cycle against a behavioural model.
module tb_y_position_mover;

  localparam int W  = 7;
  localparam int IP = 104;
  localparam int MN = 0;
  localparam int MX = 119;
  localparam int ST = 3;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         parload = 1'b0;
  logic [W-1:0] value = '0;
  logic         move_start = 1'b0;
  logic [W-1:0] target = '0;
  logic         step_up = 1'b0;
  logic         step_dn = 1'b0;
  logic [W-1:0] pos;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model state: position, whether a glide is in progress, its target,
  // and the number of cycles elapsed since busy rose.
  int m_pos = IP;
  bit m_glide = 1'b0;
  int m_tgt = 0;
  int m_age = 0;
  bit m_done = 1'b0;

  y_position_mover #(
    .WIDTH(W), .INIT(IP), .MIN_POS(MN), .MAX_POS(MX), .STEP(ST), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .resetn(resetn), .parload(parload), .value(value),
    .move_start(move_start), .target(target), .step_up(step_up),
    .step_dn(step_dn), .pos(pos), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int x);
    if (x < MN) return MN;
    if (x > MX) return MX;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int t, d;
    m_done = 1'b0;
    if (!resetn) begin
      m_pos   = IP;
      m_glide = 1'b0;
    end else if (parload) begin
      m_pos   = clampi(int'(value));
      m_glide = 1'b0;
    end else if (!m_glide) begin
      if (move_start) begin
        t = clampi(int'(target));
        if (t == m_pos) m_done = 1'b1;
        else begin
          m_glide = 1'b1;
          m_tgt   = t;
          m_age   = 0;
        end
      end else if (step_up && !step_dn) m_pos = clampi(m_pos + ST);
      else if (step_dn && !step_up)     m_pos = clampi(m_pos - ST);
    end else begin
      m_age++;
      if (m_age % TD == 0) begin
        d = m_tgt - m_pos;
        if (d > ST)       m_pos = m_pos + ST;
        else if (d < -ST) m_pos = m_pos - ST;
        else              m_pos = m_tgt;
        if (m_pos == m_tgt) begin
          m_glide = 1'b0;
          m_done  = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("pos", int'(pos), m_pos);
      chk("busy", int'(busy), int'(m_glide));
      chk("done", int'(done), int'(m_done));
    end
  end

  task automatic cmd(input bit pl, input int val, input bit ms, input int tg,
                     input bit su, input bit sd);
    parload = pl; value = W'(val); move_start = ms; target = W'(tg);
    step_up = su; step_dn = sd;
    @(negedge clk);
    parload = 1'b0; move_start = 1'b0; step_up = 1'b0; step_dn = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int exp_up[6];
    exp_up = '{107, 110, 113, 116, 119, 119};

    // Reset
    resetn = 1'b0;
    wait_n(2);
    resetn = 1'b1;
    check_en = 1'b1;
    chk("reset_pos", int'(pos), 104);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);

    // Glide down 104 -> 95
    cmd(0, 0, 1, 95, 0, 0);
    chk("glide_busy_rise", int'(busy), 1);
    wait_n(3);
    chk("glide_hold", int'(pos), 104);
    wait_n(1);
    chk("glide_101", int'(pos), 101);
    wait_n(4);
    chk("glide_98", int'(pos), 98);
    wait_n(4);
    chk("glide_95", int'(pos), 95);
    chk("glide_done", int'(done), 1);
    chk("glide_busy_fall", int'(busy), 0);
    chk("model_glide_end", m_pos, 95);
    wait_n(1);
    chk("glide_done_once", int'(done), 0);

    // Saturating steps
    cmd(1, 104, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cmd(0, 0, 0, 0, 1, 0);
      chk("step_up", int'(pos), exp_up[k]);
    end
    chk("model_step_sat", m_pos, 119);
    cmd(1, 1, 0, 0, 0, 0);
    cmd(0, 0, 0, 0, 0, 1);
    chk("step_dn_floor", int'(pos), 0);
    cmd(0, 0, 0, 0, 1, 1);
    chk("step_both", int'(pos), 0);

    // Clamped target and no-op glide
    cmd(1, 110, 0, 0, 0, 0);
    cmd(0, 0, 1, 127, 0, 0);
    wait_n(4);
    chk("clamp_113", int'(pos), 113);
    wait_n(4);
    chk("clamp_116", int'(pos), 116);
    wait_n(4);
    chk("clamp_119", int'(pos), 119);
    chk("clamp_done", int'(done), 1);
    wait_n(1);
    cmd(0, 0, 1, 119, 0, 0);
    chk("noop_done", int'(done), 1);
    chk("noop_busy", int'(busy), 0);
    chk("model_noop_done", int'(m_done), 1);
    wait_n(1);

    // Abort by parload; steps ignored while gliding
    cmd(0, 0, 1, 10, 0, 0);
    wait_n(2);
    cmd(0, 0, 0, 0, 1, 0);
    chk("glide_ignores_step", int'(pos), 119);
    wait_n(1);
    chk("abort_pre_116", int'(pos), 116);
    cmd(1, 50, 0, 0, 0, 0);
    chk("abort_pos", int'(pos), 50);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    wait_n(6);
    chk("abort_still_50", int'(pos), 50);

    // Reset mid-glide, then a fresh glide
    cmd(0, 0, 1, 80, 0, 0);
    wait_n(5);
    chk("rglide_53", int'(pos), 53);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst_mid_pos", int'(pos), 104);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    cmd(0, 0, 1, 101, 0, 0);
    chk("post_rst_busy", int'(busy), 1);
    wait_n(4);
    chk("post_rst_101", int'(pos), 101);
    chk("post_rst_done", int'(done), 1);

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      int tg;
      resetn     = ($urandom_range(0, 199) != 0);
      parload    = ($urandom_range(0, 39) == 0);
      value      = W'($urandom_range(0, 127));
      move_start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) tg = $urandom_range(0, 127);
      else begin
        tg = m_pos + int'($urandom_range(0, 16)) - 8;
        if (tg < 0) tg = 0;
        if (tg > 127) tg = 127;
      end
      target  = W'(tg);
      step_up = ($urandom_range(0, 2) == 0);
      step_dn = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    resetn = 1'b1; parload = 1'b0; move_start = 1'b0;
    step_up = 1'b0; step_dn = 1'b0;
    wait_n(2);
    check_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
